// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants for the ID-stage hazard scoreboard
package hazard_scoreboard_pkg;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         DEFAULT_DEPTH = 4;

    // Consumer stall cycles owed to each producer class
    typedef enum logic [2:0] {
        LAT_ALU    = 3'd0,
        LAT_LOAD   = 3'd1,
        LAT_MULDIV = 3'd4
    } lat_class_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - one scoreboard slot: pending destination register and remaining latency
module hazard_sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [REG_W-1:0] load_rd,
    input  logic [LAT_W-1:0] load_lat,
    input  logic [REG_W-1:0] probe_a,
    input  logic [REG_W-1:0] probe_b,
    output logic             valid,
    output logic             match_a,
    output logic             match_b
);

    logic [REG_W-1:0] rd;
    logic [LAT_W-1:0] cnt;

    // Loading only ever targets a free slot, so load and countdown never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            rd    <= '0;
            cnt   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            rd    <= load_rd;
            cnt   <= load_lat;
        end else if (valid) begin
            if (cnt > LAT_W'(1)) begin
                cnt <= cnt - LAT_W'(1);
            end else begin
                valid <= 1'b0;
            end
        end
    end

    assign match_a = valid && (rd == probe_a) && (probe_a != REG_W'(REG_ZERO));
    assign match_b = valid && (rd == probe_b) && (probe_b != REG_W'(REG_ZERO));

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage stall/flush control over a table of in-flight long-latency producers
// Optional stall-cycle statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_regwrite,
    input  logic [REG_W-1:0] id_rd,
    input  logic [LAT_W-1:0] id_latency,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             sb_full,
    output logic [31:0]      stall_cycles
);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] hit_rs;
    logic [DEPTH-1:0] hit_rt;
    logic [DEPTH-1:0] alloc_sel;
    logic             raw_hit;
    logic             need_alloc;
    logic             stall;
    logic             issue;

    assign raw_hit    = id_valid && ((|hit_rs) || (id_uses_rt && (|hit_rt)));
    assign need_alloc = id_valid && id_regwrite && (id_rd != REG_W'(REG_ZERO))
                        && (id_latency != LAT_W'(LAT_ALU));
    assign sb_full    = &ent_valid;

    // A taken branch squashes the ID instruction, so it can neither stall nor allocate
    assign stall = !branch_taken && (raw_hit || (need_alloc && sb_full));
    assign issue = need_alloc && !stall && !branch_taken;

    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall || branch_taken;
    assign ifid_flush  = branch_taken;

    // Lowest-index free slot wins; based on start-of-cycle state only
    always_comb begin
        alloc_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                alloc_sel    = '0;
                alloc_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        hazard_sb_entry #(
            .REG_W (REG_W),
            .LAT_W (LAT_W)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (issue && alloc_sel[g]),
            .load_rd  (id_rd),
            .load_lat (id_latency),
            .probe_a  (id_rs),
            .probe_b  (id_rt),
            .valid    (ent_valid[g]),
            .match_a  (hit_rs[g]),
            .match_b  (hit_rt[g])
        );
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed table-driven bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_regwrite;
    logic [4:0]  id_rd;
    logic [2:0]  id_latency;
    logic        branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        sb_full;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       rw;
        logic [4:0] rd;
        logic [2:0] lat;
        logic       br;
        logic       pcw;
        logic       bub;
        logic       fl;
        logic       full;
    } vec_t;

    vec_t tbl[$];

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_regwrite  (id_regwrite),
        .id_rd        (id_rd),
        .id_latency   (id_latency),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .sb_full      (sb_full),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic v(input logic r, input logic vl, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ut, input logic rw, input logic [4:0] rd, input logic [2:0] lat,
                     input logic br, input logic pcw, input logic bub, input logic fl,
                     input logic full);
        vec_t e;
        e = '{r, vl, rs, rt, ut, rw, rd, lat, br, pcw, bub, fl, full};
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t e);
        rst          = e.rst;
        id_valid     = e.vld;
        id_rs        = e.rs;
        id_rt        = e.rt;
        id_uses_rt   = e.ut;
        id_regwrite  = e.rw;
        id_rd        = e.rd;
        id_latency   = e.lat;
        branch_taken = e.br;
    endtask

    initial begin
        logic [31:0] exp_sc;
        int          n;
        vec_t        idle;
        vec_t        e;

        idle = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        drive(idle);
        rst = 1'b1;

        // rst vl  rs  rt  ut rw  rd  lat  br | pcw bub fl full
        v(0,1'b0,5'd0,5'd0,0,0,5'd0,3'd0,0, 1,0,0,0);               // 0 reset state
        v(0,1'b1,5'd1,5'd2,1,1,5'd8,LAT_LOAD,0, 1,0,0,0);           // 1 lw $8
        v(0,1'b1,5'd8,5'd3,1,1,5'd10,3'd0,0, 0,1,0,0);              // 2 load-use stall
        v(0,1'b1,5'd8,5'd3,1,1,5'd10,3'd0,0, 1,0,0,0);              // 3 released
        v(0,1'b1,5'd1,5'd2,1,1,5'd9,LAT_MULDIV,0, 1,0,0,0);         // 4 mul $9
        for (int i = 0; i < 4; i++) v(0,1'b1,5'd3,5'd9,1,1,5'd11,3'd0,0, 0,1,0,0);  // 5-8
        v(0,1'b1,5'd3,5'd9,1,1,5'd11,3'd0,0, 1,0,0,0);              // 9
        v(0,1'b1,5'd1,5'd2,1,1,5'd9,LAT_MULDIV,0, 1,0,0,0);         // 10 mul $9
        v(0,1'b1,5'd3,5'd9,0,1,5'd11,3'd0,0, 1,0,0,0);              // 11 rt not read
        for (int i = 0; i < 3; i++) v(0,1'b0,5'd0,5'd0,0,0,5'd0,3'd0,0, 1,0,0,0);   // 12-14
        v(0,1'b1,5'd1,5'd2,1,1,5'd0,3'd3,0, 1,0,0,0);               // 15 rd=$0 lat3
        v(0,1'b1,5'd0,5'd0,1,1,5'd13,3'd0,0, 1,0,0,0);              // 16 reads $0
        v(0,1'b1,5'd1,5'd2,1,1,5'd12,3'd0,0, 1,0,0,0);              // 17 ALU $12
        v(0,1'b1,5'd12,5'd2,1,1,5'd13,3'd0,0, 1,0,0,0);             // 18 reads $12
        v(0,1'b1,5'd1,5'd2,1,1,5'd16,3'd7,0, 1,0,0,0);              // 19
        v(0,1'b1,5'd1,5'd2,1,1,5'd17,3'd7,0, 1,0,0,0);              // 20
        v(0,1'b1,5'd1,5'd2,1,1,5'd18,3'd7,0, 1,0,0,0);              // 21
        v(0,1'b1,5'd1,5'd2,1,1,5'd19,3'd7,0, 1,0,0,0);              // 22
        for (int i = 0; i < 4; i++) v(0,1'b1,5'd1,5'd2,1,1,5'd20,3'd2,0, 0,1,0,1);  // 23-26 full
        v(0,1'b1,5'd1,5'd2,1,1,5'd20,3'd2,0, 1,0,0,0);              // 27 allocates
        v(0,1'b1,5'd20,5'd2,1,1,5'd21,3'd3,1, 1,1,1,0);             // 28 flush beats stall
        v(0,1'b1,5'd20,5'd2,1,0,5'd0,3'd0,0, 0,1,0,0);              // 29 still counting
        v(0,1'b1,5'd21,5'd20,1,0,5'd0,3'd0,0, 1,0,0,0);             // 30 no alloc happened
        v(0,1'b1,5'd1,5'd2,1,1,5'd22,3'd3,0, 1,0,0,0);              // 31
        v(0,1'b1,5'd1,5'd2,1,1,5'd22,3'd1,0, 1,0,0,0);              // 32 same rd again
        v(0,1'b1,5'd22,5'd2,1,0,5'd0,3'd0,0, 0,1,0,0);              // 33
        v(0,1'b1,5'd22,5'd2,1,0,5'd0,3'd0,0, 0,1,0,0);              // 34 older still live
        v(0,1'b1,5'd22,5'd2,1,0,5'd0,3'd0,0, 1,0,0,0);              // 35
        v(0,1'b1,5'd1,5'd2,1,1,5'd9,LAT_MULDIV,0, 1,0,0,0);         // 36
        v(0,1'b1,5'd9,5'd2,1,0,5'd0,3'd0,0, 0,1,0,0);               // 37
        v(1,1'b1,5'd9,5'd2,1,0,5'd0,3'd0,0, 0,1,0,0);               // 38 reset mid-stall
        v(0,1'b1,5'd9,5'd2,1,0,5'd0,3'd0,0, 1,0,0,0);               // 39 dropped

        repeat (2) @(posedge clk);
        exp_sc = 32'd0;
        for (int i = 0; i < tbl.size(); i++) begin
            e = tbl[i];
            @(posedge clk);
            #1;
            drive(e);
            #3;
            chk("pc_write",    i, {31'd0, pc_write},    {31'd0, e.pcw});
            chk("ifid_write",  i, {31'd0, ifid_write},  {31'd0, e.pcw});
            chk("idex_bubble", i, {31'd0, idex_bubble}, {31'd0, e.bub});
            chk("ifid_flush",  i, {31'd0, ifid_flush},  {31'd0, e.fl});
            chk("sb_full",     i, {31'd0, sb_full},     {31'd0, e.full});
            chk("stall_cycles", i, stall_cycles, exp_sc);
`ifdef HAZARD_STATS_EN
            if (e.rst) exp_sc = 32'd0;
            else if (!e.pcw) exp_sc = exp_sc + 32'd1;
`endif
        end

        // Maximum latency producer: consumer must see exactly 7 stall cycles
        @(posedge clk);
        #1;
        drive(idle);
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        id_regwrite = 1'b1; id_rd = 5'd25; id_latency = 3'd7;
        #3;
        chk("lat7_issue", 100, {31'd0, pc_write}, 32'd1);
        @(posedge clk);
        #1;
        id_rs = 5'd25; id_regwrite = 1'b0; id_rd = 5'd0; id_latency = 3'd0;
        #3;
        n = 0;
        while (!pc_write && n < 20) begin
            n++;
            @(posedge clk);
            #4;
        end
        chk("lat7_stall_len", 101, n, 32'd7);
        chk("lat7_sb_full", 101, {31'd0, sb_full}, 32'd0);
`ifdef HAZARD_STATS_EN
        exp_sc = 32'd7;
`endif
        chk("lat7_stall_cycles", 101, stall_cycles, exp_sc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
